// File: rtl/line_steer_ctrl.sv
// ---------------------------------------------------------------------------
// line_steer_ctrl
//
// Frame-based line-following steering controller. Once per control frame the
// eight IR line sensors are sampled (through a 2-flop synchronizer). The
// sensors are converted to a signed position error, and a PD law turns that
// error into differential left/right servo commands around a straight-line
// base speed. If the line stays lost for LOST_FRAMES consecutive frames, both
// commands are forced to zero and `lost` is raised. The stop is cleared at the
// first update after any sensor bit is seen again.
//
// Frame timeline (T = frame tick, the cycle in which the frame counter wraps):
//   T+1 SAMPLE  error computed from synchronized sensors, lost counter updated
//   T+2 CALC    PD correction and raw commands, prev_err updated
//   T+3 CLAMP   range clamp (and optional slew limit), outputs registered
//   T+4 UPDATE  new servo_L/servo_R visible, upd high for this one cycle
// FRAME_CYCLES must be at least 5 so that a frame fits in one period.
//
// Optional feature: define STEER_SLEW_EN to limit each command's change per
// frame to +/- SLEW_STEP (after range clamping). The lost-line stop bypasses
// the slew limit.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous reset, active low
//   sensor   in   8   IR line sensors (1 = line), bit0 leftmost, asynchronous
//   servo_L  out  11  left servo command, 0..SERVO_MAX, registered
//   servo_R  out  11  right servo command, 0..SERVO_MAX, registered
//   upd      out  1   one-cycle pulse coincident with new servo values
//   lost     out  1   high while the lost-line stop is in force
// ---------------------------------------------------------------------------
module line_steer_ctrl #(
    parameter int FRAME_CYCLES = 2000000,
    parameter int BASE_SPEED   = 600,
    parameter int KP           = 20,
    parameter int KD           = 10,
    parameter int SERVO_MAX    = 1000,
    parameter int LOST_FRAMES  = 25,
    parameter int SLEW_STEP    = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sensor,
    output logic [10:0] servo_L,
    output logic [10:0] servo_R,
    output logic        upd,
    output logic        lost
);

    localparam int CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int LCNT_W = (LOST_FRAMES > 0) ? $clog2(LOST_FRAMES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LOST_LIM    = LCNT_W'(LOST_FRAMES);
    localparam logic signed [5:0] ERR_FULL    = 6'sd16;
    localparam logic signed [15:0] KP_S       = 16'(KP);
    localparam logic signed [15:0] KD_S       = 16'(KD);
    localparam logic signed [15:0] BASE_S     = 16'(BASE_SPEED);
    localparam logic signed [15:0] SERVO_MAX_S = 16'(SERVO_MAX);
    localparam logic [10:0]        SERVO_MAX_U = 11'(SERVO_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CALC,
        S_CLAMP,
        S_UPDATE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  frame_cnt;
    logic              frame_tick;

    logic [7:0]        sens_meta;
    logic [7:0]        sens_sync;

    logic              ld_sample;
    logic              ld_calc;
    logic              ld_out;

    logic signed [5:0] err_nxt;
    logic signed [5:0] err_p0;
    logic signed [5:0] prev_err;
    logic [LCNT_W-1:0] lost_cnt;

    logic signed [15:0] err_w;
    logic signed [15:0] prev_w;
    logic signed [15:0] corr;
    logic signed [15:0] raw_l_nxt;
    logic signed [15:0] raw_r_nxt;
    logic signed [15:0] raw_l_p1;
    logic signed [15:0] raw_r_p1;

    logic              lost_now;
    logic [10:0]       out_l_nxt;
    logic [10:0]       out_r_nxt;

    // Position error from one sensor snapshot. Weights are -7,-5,..,+7 from
    // bit0 to bit7. A full bar (crossing/stop line) reads as centred. With no
    // line visible, the error is pushed to the extreme on the side the line was
    // last seen, so the robot keeps turning back towards it.
    function automatic logic signed [5:0] line_error(input logic [7:0] s,
                                                     input logic signed [5:0] prev);
        logic signed [5:0] acc;
        acc = 6'sd0;
        if (s == 8'hFF) begin
            acc = 6'sd0;
        end else if (s == 8'h00) begin
            if (prev > 6'sd0)
                acc = ERR_FULL;
            else if (prev < 6'sd0)
                acc = -ERR_FULL;
            else
                acc = 6'sd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s[i])
                    acc = acc + 6'(2 * i - 7);
            end
        end
        return acc;
    endfunction

    // Saturate a signed raw command into the servo range 0..SERVO_MAX.
    function automatic logic [10:0] sat_servo(input logic signed [15:0] v);
        if (v < 16'sd0)
            return 11'd0;
        else if (v > SERVO_MAX_S)
            return SERVO_MAX_U;
        else
            return v[10:0];
    endfunction

`ifdef STEER_SLEW_EN
    localparam logic [11:0] SLEW_U = 12'(SLEW_STEP);

    // Limit the move from the current command to at most SLEW_U either way.
    function automatic logic [10:0] slew_limit(input logic [10:0] target,
                                               input logic [10:0] cur);
        logic [11:0] t;
        logic [11:0] c;
        t = {1'b0, target};
        c = {1'b0, cur};
        if (t > c + SLEW_U)
            return 11'(c + SLEW_U);
        else if (t + SLEW_U < c)
            return 11'(c - SLEW_U);
        else
            return target;
    endfunction
`else
    logic unused_slew_step;
    assign unused_slew_step = (SLEW_STEP != 0);
`endif

    // Frame counter: the cycle holding the last count is the frame tick.
    assign frame_tick = (frame_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    // Sensor synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sens_meta <= '0;
            sens_sync <= '0;
        end else begin
            sens_meta <= sensor;
            sens_sync <= sens_meta;
        end
    end

    // Frame sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_sample = 1'b0;
        ld_calc   = 1'b0;
        ld_out    = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_tick)
                    state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                ld_sample = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: begin
                ld_calc   = 1'b1;
                state_nxt = S_CLAMP;
            end
            S_CLAMP: begin
                ld_out    = 1'b1;
                state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- Stage p0: sample sensors into a position error ----
    assign err_nxt = line_error(sens_sync, prev_err);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_p0   <= '0;
            lost_cnt <= '0;
        end else if (ld_sample) begin
            err_p0 <= err_nxt;
            if (sens_sync == 8'h00) begin
                if (lost_cnt < LOST_LIM)
                    lost_cnt <= lost_cnt + 1'b1;
            end else begin
                lost_cnt <= '0;
            end
        end
    end

    // ---- Stage p1: PD correction and raw differential commands ----
    always_comb begin
        err_w     = {{10{err_p0[5]}}, err_p0};
        prev_w    = {{10{prev_err[5]}}, prev_err};
        corr      = KP_S * err_w + KD_S * (err_w - prev_w);
        raw_l_nxt = BASE_S + corr;
        raw_r_nxt = BASE_S - corr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_l_p1 <= '0;
            raw_r_p1 <= '0;
            prev_err <= '0;
        end else if (ld_calc) begin
            raw_l_p1 <= raw_l_nxt;
            raw_r_p1 <= raw_r_nxt;
            prev_err <= err_p0;
        end
    end

    // ---- Stage p2: clamp, optional slew, lost-line stop, output load ----
    assign lost_now = (lost_cnt >= LOST_LIM);

    always_comb begin
        out_l_nxt = sat_servo(raw_l_p1);
        out_r_nxt = sat_servo(raw_r_p1);
`ifdef STEER_SLEW_EN
        out_l_nxt = slew_limit(out_l_nxt, servo_L);
        out_r_nxt = slew_limit(out_r_nxt, servo_R);
`endif
        // The stop is applied last so it takes effect immediately.
        if (lost_now) begin
            out_l_nxt = 11'd0;
            out_r_nxt = 11'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            servo_L <= '0;
            servo_R <= '0;
            upd     <= 1'b0;
            lost    <= 1'b0;
        end else begin
            upd <= ld_out;
            if (ld_out) begin
                servo_L <= out_l_nxt;
                servo_R <= out_r_nxt;
                lost    <= lost_now;
            end
        end
    end

endmodule

// File: tb/tb_line_steer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_steer_ctrl
//
// Directed + randomized bench for line_steer_ctrl with FRAME_CYCLES = 100.
// A frame-level reference model (plain integer arithmetic on the control law)
// predicts each update; named anchor values are also compared directly.
// ---------------------------------------------------------------------------
module tb_line_steer_ctrl;

    localparam int FC    = 100;
    localparam int BASE  = 600;
    localparam int KP    = 20;
    localparam int KD    = 10;
    localparam int SMAX  = 1000;
    localparam int LOSTN = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sensor;
    logic [10:0] servo_L;
    logic [10:0] servo_R;
    logic        upd;
    logic        lost;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_prev;
    int m_lost_cnt;
    int m_L;
    int m_R;
    int m_lost;

    line_steer_ctrl #(
        .FRAME_CYCLES(FC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sensor  (sensor),
        .servo_L (servo_L),
        .servo_R (servo_R),
        .upd     (upd),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > SMAX) return SMAX;
        return v;
    endfunction

    task automatic model_reset();
        m_prev     = 0;
        m_lost_cnt = 0;
        m_L        = 0;
        m_R        = 0;
        m_lost     = 0;
    endtask

    // One whole frame of the control law, from the sensor word to the outputs.
    task automatic model_frame(input logic [7:0] s);
        int err;
        int corr;
        int ones;
        ones = $countones(s);
        err  = 0;
        if (ones == 0) begin
            if (m_prev > 0)      err = 16;
            else if (m_prev < 0) err = -16;
            m_lost_cnt++;
        end else begin
            m_lost_cnt = 0;
            if (ones != 8)
                for (int i = 0; i < 8; i++)
                    if (s[i]) err += 2 * i - 7;
        end
        corr   = KP * err + KD * (err - m_prev);
        m_prev = err;
        if (m_lost_cnt >= LOSTN) begin
            m_L = 0; m_R = 0; m_lost = 1;
        end else begin
            m_L = clampv(BASE + corr);
            m_R = clampv(BASE - corr);
            m_lost = 0;
        end
    endtask

    task automatic wait_upd(input int limit, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (upd === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_L"}, {21'b0, servo_L}, 32'(m_L));
        check({tag, "_R"}, {21'b0, servo_R}, 32'(m_R));
        check({tag, "_lost"}, {31'b0, lost}, 32'(m_lost));
    endtask

    // Apply s for one frame and check the resulting update. gap is the number
    // of clock edges expected from the call to the upd pulse. With glitch set,
    // the sensor is inverted right after the sampling window closes.
    task automatic run_frame(input logic [7:0] s, input int gap, input bit glitch, input string tag);
        int edges;
        int pre;
        bit seen;
        sensor = s;
        pre = 0;
        if (glitch) begin
            repeat (98) @(posedge clk);
            #1;
            sensor = ~s;
            pre = 98;
        end
        wait_upd(FC + 20, edges, seen);
        check({tag, "_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_gap"}, 32'(pre + edges), 32'(gap));
        model_frame(s);
        check_outputs(tag);
    endtask

    initial begin
        int edges;
        bit seen;
        logic [7:0] s;
        int r;

        // Reset state
        rst    = 1'b0;
        sensor = 8'b0001_1000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_L", {21'b0, servo_L}, 32'd0);
        check("rst_R", {21'b0, servo_R}, 32'd0);
        check("rst_upd", {31'b0, upd}, 32'd0);
        check("rst_lost", {31'b0, lost}, 32'd0);

        // First frame after release; the release cycle is cycle 1.
        @(negedge clk);
        rst = 1'b1;
        wait_upd(FC + 20, edges, seen);
        check("first_seen", {31'b0, seen}, 32'd1);
        check("first_upd_cycle", 32'(edges + 1), 32'd104);
        model_frame(8'b0001_1000);
        check_outputs("first");
        check("first_L_anchor", {21'b0, servo_L}, 32'd600);
        check("first_R_anchor", {21'b0, servo_R}, 32'd600);

        @(posedge clk);
        #1;
        check("upd_pulse_width", {31'b0, upd}, 32'd0);

        // PD response and derivative decay
        run_frame(8'b1100_0000, 99, 1'b0, "pd1");
        check("pd1_L_anchor", {21'b0, servo_L}, 32'd960);
        check("pd1_R_anchor", {21'b0, servo_R}, 32'd240);
        run_frame(8'b1100_0000, 100, 1'b0, "pd2");
        check("pd2_L_anchor", {21'b0, servo_L}, 32'd840);
        check("pd2_R_anchor", {21'b0, servo_R}, 32'd360);

        // Line lost: extreme error, then stop after 25 frames
        for (int i = 0; i < LOSTN; i++) begin
            run_frame(8'h00, 100, 1'b0, "lostf");
            if (i == 0) begin
                check("lost1_L_anchor", {21'b0, servo_L}, 32'd960);
                check("lost1_R_anchor", {21'b0, servo_R}, 32'd240);
            end
            if (i == LOSTN - 2)
                check("lost24_flag", {31'b0, lost}, 32'd0);
        end
        check("lost25_flag", {31'b0, lost}, 32'd1);
        check("lost25_L", {21'b0, servo_L}, 32'd0);
        check("lost25_R", {21'b0, servo_R}, 32'd0);
        run_frame(8'h00, 100, 1'b0, "lost_sat");
        run_frame(8'b0001_1000, 100, 1'b0, "recover");
        check("recover_lost", {31'b0, lost}, 32'd0);
        check("recover_L_anchor", {21'b0, servo_L}, 32'd440);
        check("recover_R_anchor", {21'b0, servo_R}, 32'd760);

        // Single edge sensor, then saturation at SERVO_MAX
        run_frame(8'b1000_0000, 100, 1'b0, "edge7");
        check("edge7_L_anchor", {21'b0, servo_L}, 32'd810);
        check("edge7_R_anchor", {21'b0, servo_R}, 32'd390);
        run_frame(8'b0001_1000, 100, 1'b0, "centre");
        run_frame(8'b1111_0000, 100, 1'b0, "sat");
        check("sat_L_anchor", {21'b0, servo_L}, 32'd1000);
        check("sat_R_anchor", {21'b0, servo_R}, 32'd120);

        // Crossing line reads as centred
        run_frame(8'b0001_1000, 100, 1'b0, "centre2");
        run_frame(8'hFF, 100, 1'b0, "cross");
        check("cross_L_anchor", {21'b0, servo_L}, 32'd600);
        check("cross_R_anchor", {21'b0, servo_R}, 32'd600);

        // Sensor change after the sample must not affect the frame
        run_frame(8'b0000_0011, 100, 1'b1, "glitch");

        // Randomized frames
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      s = 8'h00;
            else if (r == 1) s = 8'hFF;
            else             s = 8'($urandom_range(1, 254));
            run_frame(s, 100, 1'b0, "rand");
        end

        // Reset pulse at T+2 of a frame aborts it
        sensor = 8'b0001_1000;
        repeat (98) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("midrst_L", {21'b0, servo_L}, 32'd0);
        check("midrst_R", {21'b0, servo_R}, 32'd0);
        check("midrst_upd", {31'b0, upd}, 32'd0);
        check("midrst_lost", {31'b0, lost}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_upd(FC + 20, edges, seen);
        check("midrst_seen", {31'b0, seen}, 32'd1);
        check("midrst_upd_cycle", 32'(edges + 1), 32'd104);
        model_frame(8'b0001_1000);
        check_outputs("midrst_frame");
        run_frame(8'b0110_0000, 100, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/line_steer_ctrl.md
LINE_STEER_CTRL -- requirements
Module: line_steer_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 2000000: clk cycles per control frame (20 ms at 100 MHz).
REQ-002 Parameter BASE_SPEED, default 600: straight-line servo command.
REQ-003 Parameter KP, default 20: proportional gain, unsigned, 0..63.
REQ-004 Parameter KD, default 10: derivative gain, unsigned, 0..63.
REQ-005 Parameter SERVO_MAX, default 1000: upper clamp for both commands.
REQ-006 Parameter LOST_FRAMES, default 25: consecutive line-lost frames before stop.
REQ-007 Parameter SLEW_STEP, default 50: maximum per-frame command change; used only under STEER_SLEW_EN.
REQ-008 One clock; reset is asynchronous and active-low.
REQ-009 clk  in  1  system clock, all logic on rising edge.
REQ-010 rst  in  1  asynchronous active-low reset.
REQ-011 sensor  in  8  IR line sensors, 1 = line detected, asynchronous to clk; bit0 leftmost, bit7 rightmost.
REQ-012 servo_L  out  11  left servo command, 0..SERVO_MAX, registered.
REQ-013 servo_R  out  11  right servo command, 0..SERVO_MAX, registered.
REQ-014 upd  out  1  one-cycle pulse coincident with new servo_L/servo_R values.
REQ-015 lost  out  1  high while the stop condition of REQ-024 holds.

Function
REQ-016 sensor SHALL pass through a 2-flop synchronizer before any use.
REQ-017 A frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; the wrap cycle is the frame tick.
REQ-018 FSM states: IDLE, SAMPLE, CALC, CLAMP, UPDATE; IDLE->SAMPLE on frame tick, then one state per cycle, UPDATE->IDLE unconditionally.
REQ-019 Latency: frame tick in cycle T; sensor sampled at T+1; outputs and upd change at T+4; upd high exactly one cycle per frame.
REQ-020 SAMPLE: err = signed sum of weights -7,-5,-3,-1,+1,+3,+5,+7 for active bits 0..7; range -16..+16, 6-bit signed.
REQ-021 All eight bits set (crossing/stop line): err = 0.
REQ-022 No bits set: err = +16 if prev_err > 0, -16 if prev_err < 0, 0 if prev_err = 0; lost counter increments (saturating); any set bit clears it.
REQ-023 CALC: corr = KP*err + KD*(err - prev_err), signed 16-bit; raw_L = BASE_SPEED + corr, raw_R = BASE_SPEED - corr, signed 16-bit; prev_err <= err.
REQ-024 When lost counter >= LOST_FRAMES: lost = 1, next outputs 0/0; lost drops at the first UPDATE after a sensor bit is seen, commands resuming per REQ-023.
REQ-025 CLAMP: values < 0 become 0, values > SERVO_MAX become SERVO_MAX.
REQ-026 UPDATE: servo_L/servo_R load clamped values; upd = 1.
REQ-027 Sensor changes outside SAMPLE SHALL have no effect on the current frame.

Reset
REQ-028 On rst low: servo_L = 0, servo_R = 0, upd = 0, lost = 0, prev_err = 0, lost counter = 0, frame counter = 0, FSM = IDLE, synchronizer flops = 0.
REQ-029 Reset asserted mid-frame or mid-FSM SHALL abort the frame; no upd until a full FRAME_CYCLES after release.
REQ-030 First frame tick SHALL occur FRAME_CYCLES cycles after rst release.

Configuration
REQ-031 Macro STEER_SLEW_EN defined: CLAMP additionally limits each output to previous value +/- SLEW_STEP, applied after range clamp; stop per REQ-024 bypasses slew (immediate 0).
REQ-032 STEER_SLEW_EN undefined: no slew logic; clamped values load directly.

Verification (FRAME_CYCLES = 100 for simulation, other defaults)
REQ-033 Reset release, sensor=8'b0001_1000 -> first upd at cycle 104 after release, servo_L=600, servo_R=600, lost=0.
REQ-034 From prev_err=0, sensor=8'b1100_0000 -> err=12, servo_L=960, servo_R=240; next frame same input -> servo_L=840, servo_R=360.
REQ-035 After err=12, sensor=0 -> err=16, servo_L=960, servo_R=240; held 25 frames -> lost=1, outputs 0/0; then sensor=8'b0001_1000 -> lost=0, err=0, corr=-160, servo_L=440, servo_R=760.
REQ-036 From prev_err=0, sensor=8'b1000_0000 -> err=7, corr=210 -> 810/390; from prev_err=0, sensor=8'b1111_0000 -> err=16, raw_L=1080 -> servo_L=1000, servo_R=120.
REQ-037 sensor=8'hFF -> err=0 with prev_err=0 -> 600/600; rst pulsed low at T+2 of a frame -> outputs 0/0, no upd that frame.
REQ-038 STEER_SLEW_EN defined, outputs 600/600, sensor=8'b1100_0000 -> servo_L=650, servo_R=550.
